// File: rtl/board_renderer_if.sv
// Board RAM read port between board_renderer (master) and the double-buffered
// board RAM (slave). The address MSB selects the buffer.
interface board_renderer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/board_renderer.sv
// Game of Life pixel renderer: maps VGA timing to board cells, reads cell state
// from board RAM, emits RGB with matched syncs. Optional grid lines: GRID_LINES_EN.
module board_renderer #(
  parameter int          CELL_SHIFT     = 3,
  parameter int          BOARD_W        = 64,
  parameter int          BOARD_H        = 48,
  parameter int          WORD_BITS      = 16,
  parameter int          READ_LATENCY   = 2,
  parameter int          DISPLAY_HEIGHT = 480,
  parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR     = 12'h000,
  parameter logic [11:0] CURSOR_COLOR   = 12'hF00
`ifdef GRID_LINES_EN
  , parameter logic [11:0] GRID_COLOR   = 12'h333
`endif
) (
  input  logic                       vclk_in,
  input  logic                       rst_n_in,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blank_in,
  input  logic [$clog2(BOARD_W)-1:0] cursor_x_in,
  input  logic [$clog2(BOARD_H)-1:0] cursor_y_in,
  input  logic                       swap_req_in,
  board_renderer_if.master           ram,
  output logic                       buf_sel_out,
  output logic                       frame_done_out,
  output logic [11:0]                rgb_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out
);

  localparam int CX_W  = $clog2(BOARD_W);
  localparam int CY_W  = $clog2(BOARD_H);
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam int IDX_W = CX_W + CY_W;
  localparam int WA_W  = IDX_W - BIT_W;
  localparam logic [CELL_SHIFT-1:0] SUB_LAST = '1;

  // Everything known about a pixel at address time, carried alongside the RAM read.
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic             on_board;
    logic             cursor_hit;
    logic             cell_edge;
`ifdef GRID_LINES_EN
    logic             grid;
`endif
    logic [BIT_W-1:0] bit_idx;
  } attr_t;

  attr_t                pipe [READ_LATENCY+1];
  attr_t                attr_idle;
  attr_t                cap;
  attr_t                tail;
  logic [10:0]          cell_x;
  logic [9:0]           cell_y;
  logic [CELL_SHIFT-1:0] sub_x;
  logic [CELL_SHIFT-1:0] sub_y;
  logic [IDX_W-1:0]     idx;
  logic                 on_board;
  logic                 frame_start;
  logic                 pending;
  logic                 buf_next;
  logic                 alive;
  logic [11:0]          colour;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    attr_idle       = '0;
    attr_idle.hsync = 1'b1;
    attr_idle.vsync = 1'b1;
    attr_idle.blank = 1'b1;

    cell_x      = hcount_in >> CELL_SHIFT;
    cell_y      = vcount_in >> CELL_SHIFT;
    sub_x       = hcount_in[CELL_SHIFT-1:0];
    sub_y       = vcount_in[CELL_SHIFT-1:0];
    on_board    = (cell_x < 11'(BOARD_W)) && (cell_y < 10'(BOARD_H));
    idx         = {cell_y[CY_W-1:0], cell_x[CX_W-1:0]};
    frame_start = (hcount_in == '0) && (vcount_in == '0);
    // The frame-start pixel already reads from the newly selected buffer.
    buf_next    = buf_sel_out ^ (frame_start & (pending | swap_req_in));

    cap            = '0;
    cap.hsync      = hsync_in;
    cap.vsync      = vsync_in;
    cap.blank      = blank_in;
    cap.on_board   = on_board;
    cap.cursor_hit = on_board && (cell_x == 11'(cursor_x_in)) && (cell_y == 10'(cursor_y_in));
    cap.cell_edge  = (sub_x == '0) || (sub_x == SUB_LAST) || (sub_y == '0) || (sub_y == SUB_LAST);
`ifdef GRID_LINES_EN
    cap.grid       = on_board && ((sub_x == '0) || (sub_y == '0));
`endif
    cap.bit_idx    = idx[BIT_W-1:0];
  end

  always_comb begin
    tail   = pipe[READ_LATENCY];
    alive  = tail.on_board & ram.rd_data[tail.bit_idx];
    colour = DEAD_COLOR;
    if (tail.blank)                             colour = 12'h000;
    else if (tail.cursor_hit && tail.cell_edge) colour = CURSOR_COLOR;
    else if (alive)                             colour = ALIVE_COLOR;
`ifdef GRID_LINES_EN
    else if (tail.grid)                         colour = GRID_COLOR;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so the pipe shifts as one.
  always_ff @(posedge vclk_in) begin
    if (!rst_n_in) begin
      buf_sel_out    <= 1'b0;
      pending        <= 1'b0;
      frame_done_out <= 1'b0;
      ram.rd_addr    <= '0;
      // NOTE: the delay line is reset stage by stage so a mid-frame reset flushes stale pixels.
      for (int i = 0; i <= READ_LATENCY; i++) pipe[i] <= attr_idle;
      rgb_out        <= 12'h000;
      hsync_out      <= 1'b1;
      vsync_out      <= 1'b1;
      blank_out      <= 1'b1;
    end else begin
      buf_sel_out    <= buf_next;
      pending        <= frame_start ? 1'b0 : (pending | swap_req_in);
      frame_done_out <= (hcount_in == '0) && (vcount_in == 10'(DISPLAY_HEIGHT));
      ram.rd_addr    <= on_board ? {buf_next, idx[IDX_W-1:BIT_W]} : {buf_next, {WA_W{1'b0}}};
      pipe[0]        <= cap;
      for (int i = 1; i <= READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      rgb_out        <= colour;
      hsync_out      <= tail.hsync;
      vsync_out      <= tail.vsync;
      blank_out      <= tail.blank;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: directed vector table, frame sequences
// for swap/frame_done/sync alignment, and random pixels against a cell-level model.
module tb_board_renderer;

  localparam int R = 2;
  localparam int L = R + 2;
`ifdef GRID_LINES_EN
  localparam logic [11:0] GRID_C = 12'h333;
`else
  localparam logic [11:0] GRID_C = 12'h000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank, swap_req;
  logic [5:0]  cur_x, cur_y;
  logic        buf_sel, frame_done, hs_o, vs_o, bl_o;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  board_renderer_if #(.ADDR_W(9), .DATA_W(16)) ram ();

  board_renderer #(.READ_LATENCY(R)) dut (
    .vclk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .cursor_x_in(cur_x), .cursor_y_in(cur_y), .swap_req_in(swap_req),
    .ram(ram), .buf_sel_out(buf_sel), .frame_done_out(frame_done),
    .rgb_out(rgb), .hsync_out(hs_o), .vsync_out(vs_o), .blank_out(bl_o)
  );

  // Board RAM: two buffers of 256 words, READ_LATENCY register stages.
  logic [15:0] mem [512];
  logic [15:0] rd_pipe [R];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram.rd_addr];
    for (int i = 1; i < R; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram.rd_data = rd_pipe[R-1];

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, bl;
    bit          tab;
    logic [11:0] tab_rgb;
  } pix_exp_t;

  typedef struct {
    logic [8:0] addr;
    logic       bsel;
    logic       fd;
    bit         tab;
    logic [8:0] tab_addr;
  } now_exp_t;

  pix_exp_t q[$];
  now_exp_t nx;
  bit m_buf, m_pend;

  // Cell-level reference: what the screen should show for one pixel.
  function automatic void model(input int px, input int py, input logic bl, input int cx,
                                input int cy, input bit bsel, output logic [11:0] c,
                                output logic [8:0] addr);
    int  cellx = px / 8;
    int  celly = py / 8;
    bit  on    = (cellx < 64) && (celly < 48);
    int  idx   = celly * 64 + cellx;
    bit  edg   = (px % 8 == 0) || (px % 8 == 7) || (py % 8 == 0) || (py % 8 == 7);
    bit  hit   = on && (cellx == cx) && (celly == cy);
    bit  alive = on && mem[(bsel ? 256 : 0) + idx / 16][idx % 16];
    bit  grid  = on && ((px % 8 == 0) || (py % 8 == 0));
    if (bl)              c = 12'h000;
    else if (hit && edg) c = 12'hF00;
    else if (alive)      c = 12'hFFF;
    else if (grid)       c = GRID_C;
    else                 c = 12'h000;
    addr = on ? 9'((bsel ? 256 : 0) + idx / 16) : (bsel ? 9'h100 : 9'h000);
  endfunction

  task automatic check_outputs();
    pix_exp_t e;
    if (frame_done) fd_count++;
    check("rd_addr", 32'(ram.rd_addr), 32'(nx.addr));
    check("buf_sel", 32'(buf_sel), 32'(nx.bsel));
    check("frame_done", 32'(frame_done), 32'(nx.fd));
    if (nx.tab) check("table_rd_addr", 32'(ram.rd_addr), 32'(nx.tab_addr));
    if (q.size() == L) begin
      e = q.pop_front();
      check("rgb", 32'(rgb), 32'(e.rgb));
      check("hsync_out", 32'(hs_o), 32'(e.hs));
      check("vsync_out", 32'(vs_o), 32'(e.vs));
      check("blank_out", 32'(bl_o), 32'(e.bl));
      if (e.tab) check("table_rgb", 32'(rgb), 32'(e.tab_rgb));
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic hs, input logic vs,
                       input logic bl, input logic swp, input logic [5:0] cx, input logic [5:0] cy,
                       input bit tab, input logic [11:0] t_rgb, input logic [8:0] t_addr);
    pix_exp_t e;
    logic [11:0] c;
    logic [8:0]  a;
    hcount = h; vcount = v; hsync = hs; vsync = vs; blank = bl;
    swap_req = swp; cur_x = cx; cur_y = cy;
    if (h == 0 && v == 0) begin
      if (m_pend || swp) m_buf = ~m_buf;
      m_pend = 1'b0;
    end else if (swp) begin
      m_pend = 1'b1;
    end
    model(int'(h), int'(v), bl, int'(cx), int'(cy), m_buf, c, a);
    e.rgb = c; e.hs = hs; e.vs = vs; e.bl = bl; e.tab = tab; e.tab_rgb = t_rgb;
    q.push_back(e);
    nx.addr = a; nx.bsel = m_buf; nx.fd = (h == 0 && v == 480);
    nx.tab = tab; nx.tab_addr = t_addr;
  endtask

  task automatic cyc(input logic [10:0] h, input logic [9:0] v, input logic hs, input logic vs,
                     input logic bl, input logic swp, input logic [5:0] cx, input logic [5:0] cy,
                     input bit tab, input logic [11:0] t_rgb, input logic [8:0] t_addr);
    @(negedge clk);
    check_outputs();
    drive(h, v, hs, vs, bl, swp, cx, cy, tab, t_rgb, t_addr);
  endtask

  task automatic do_reset(input int n);
    pix_exp_t idle;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_rgb", 32'(rgb), 32'h000);
      check("rst_hsync", 32'(hs_o), 32'h1);
      check("rst_vsync", 32'(vs_o), 32'h1);
      check("rst_blank", 32'(bl_o), 32'h1);
      check("rst_rd_addr", 32'(ram.rd_addr), 32'h0);
      check("rst_buf_sel", 32'(buf_sel), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
    end
    rst_n = 1'b1;
    q.delete();
    idle.rgb = 12'h000; idle.hs = 1'b1; idle.vs = 1'b1; idle.bl = 1'b1;
    idle.tab = 1'b0; idle.tab_rgb = 12'h000;
    repeat (L - 1) q.push_back(idle);
    m_buf = 1'b0; m_pend = 1'b0;
    drive(11'd700, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 6'd3, 1'b0, 12'h000, 9'h0);
  endtask

  // One pixel of a 640x480 style frame, syncs and blank derived from position.
  task automatic pix(input int h, input int v, input logic swp);
    cyc(11'(h), 10'(v), !(h >= 656 && h < 752), !(v >= 490 && v < 492),
        (h >= 640) || (v >= 480), swp, 6'd2, 6'd3, 1'b0, 12'h000, 9'h0);
  endtask

  int hl [11] = '{0, 1, 7, 8, 639, 640, 655, 656, 751, 752, 799};

  task automatic run_frame(input bit full10, input int sa, input int sb, input bit s0);
    fd_count = 0;
    for (int v = 0; v < 525; v++) begin
      if (full10 && v == 10) begin
        for (int h = 0; h < 800; h++) pix(h, v, 1'b0);
      end else begin
        for (int k = 0; k < 11; k++)
          pix(hl[k], v, (hl[k] == 8 && (v == sa || v == sb)) || (s0 && hl[k] == 0 && v == 0));
      end
    end
    check("frame_done_per_frame", 32'(fd_count), 32'd1);
  endtask

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        bl;
    logic [5:0]  cx, cy;
    logic [11:0] rgb;
    logic [8:0]  addr;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{11'd0,   10'd8,   1'b0, 6'd2,  6'd3,  12'hFFF, 9'd4};
    vt[1]  = '{11'd3,   10'd8,   1'b0, 6'd2,  6'd3,  12'hFFF, 9'd4};
    vt[2]  = '{11'd7,   10'd8,   1'b0, 6'd2,  6'd3,  12'hFFF, 9'd4};
    vt[3]  = '{11'd8,   10'd8,   1'b0, 6'd2,  6'd3,  GRID_C,  9'd4};
    vt[4]  = '{11'd12,  10'd12,  1'b0, 6'd2,  6'd3,  12'h000, 9'd4};
    vt[5]  = '{11'd0,   10'd0,   1'b0, 6'd2,  6'd3,  12'hFFF, 9'd0};
    vt[6]  = '{11'd16,  10'd24,  1'b0, 6'd2,  6'd3,  12'hF00, 9'd12};
    vt[7]  = '{11'd19,  10'd27,  1'b0, 6'd2,  6'd3,  12'hFFF, 9'd12};
    vt[8]  = '{11'd23,  10'd27,  1'b0, 6'd2,  6'd3,  12'hF00, 9'd12};
    vt[9]  = '{11'd19,  10'd31,  1'b0, 6'd2,  6'd3,  12'hF00, 9'd12};
    vt[10] = '{11'd20,  10'd28,  1'b0, 6'd2,  6'd3,  12'hFFF, 9'd12};
    vt[11] = '{11'd512, 10'd0,   1'b0, 6'd2,  6'd3,  12'h000, 9'd0};
    vt[12] = '{11'd100, 10'd384, 1'b0, 6'd2,  6'd3,  12'h000, 9'd0};
    vt[13] = '{11'd0,   10'd8,   1'b1, 6'd2,  6'd3,  12'h000, 9'd4};
    vt[14] = '{11'd504, 10'd376, 1'b0, 6'd63, 6'd47, 12'hF00, 9'd191};
    vt[15] = '{11'd511, 10'd383, 1'b0, 6'd63, 6'd47, 12'hF00, 9'd191};
    vt[16] = '{11'd507, 10'd379, 1'b0, 6'd63, 6'd47, 12'hFFF, 9'd191};
    vt[17] = '{11'd499, 10'd379, 1'b0, 6'd63, 6'd47, 12'h000, 9'd191};
    vt[18] = '{11'd8,   10'd8,   1'b0, 6'd1,  6'd1,  12'hF00, 9'd4};

    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001; mem[4] = 16'h0001; mem[12] = 16'h0004; mem[191] = 16'h8000;

    rst_n = 1'b0; hcount = 11'd300; vcount = 10'd50; hsync = 1'b1; vsync = 1'b1;
    blank = 1'b0; swap_req = 1'b0; cur_x = 6'd2; cur_y = 6'd3;
    m_buf = 1'b0; m_pend = 1'b0;
    nx = '{9'h0, 1'b0, 1'b0, 1'b0, 9'h0};
    do_reset(5);

    for (int i = 0; i < 19; i++)
      cyc(vt[i].h, vt[i].v, 1'b1, 1'b1, vt[i].bl, 1'b0, vt[i].cx, vt[i].cy, 1'b1, vt[i].rgb, vt[i].addr);

    run_frame(1'b1, -1, -1, 1'b0);
    check("buf_after_plain_frame", 32'(buf_sel), 32'd0);
    run_frame(1'b0, 100, -1, 1'b0);
    check("buf_held_until_origin", 32'(buf_sel), 32'd0);
    run_frame(1'b0, -1, -1, 1'b0);
    check("buf_toggled_at_origin", 32'(buf_sel), 32'd1);
    run_frame(1'b0, 200, 300, 1'b1);
    check("buf_toggled_by_origin_pulse", 32'(buf_sel), 32'd0);
    run_frame(1'b0, -1, -1, 1'b0);
    check("buf_two_pulses_one_toggle", 32'(buf_sel), 32'd1);

    pix(333, 77, 1'b0);
    do_reset(5);

    begin
      logic [5:0] rcx, rcy;
      rcx = 6'd2; rcy = 6'd3;
      for (int n = 0; n < 3000; n++) begin
        int r, h, v;
        if (n % 64 == 0) begin
          rcx = 6'($urandom_range(0, 63));
          rcy = 6'($urandom_range(0, 47));
        end
        r = int'($urandom_range(0, 39));
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
        if (r == 0) begin h = 0; v = 0; end
        if (r == 1) begin h = 0; v = 480; end
        cyc(11'(h), 10'(v), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) == 0, rcx, rcy, 1'b0, 12'h000, 9'h0);
      end
    end

    repeat (L + 1) pix(700, 10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
